// File: rtl/word_assembler_rx_pkg.sv
// Shared framing constants for the word serializer link (TX and RX sides).
// Byte order is MSB first, followed by a single trailer byte.
package word_assembler_rx_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    localparam logic [BYTE_W-1:0] TRAILER_DEF   = 8'h01;
    localparam logic [WORD_W-1:0] ADDR_WORD_DEF = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TRAIL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/word_assembler_rx_timeout_timer.sv
// Inter-byte idle timer: counts cycles while running, flags expiry at the limit.
// Saturates at the limit so a held expiry cannot wrap before the FSM reacts.
module rx_timeout_timer #(
    parameter int TO_W           = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (run_i && (cnt_q != LIMIT))
            cnt_d = cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/word_assembler_rx.sv
// Rebuilds 32-bit words from a UART RX byte stream (4 data bytes MSB first + trailer).
// Emits 1-cycle strobes for good words, bad trailers and inter-byte timeouts.
module word_assembler_rx
    import word_assembler_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] TRAILER        = TRAILER_DEF,
    parameter logic [WORD_W-1:0] ADDR_WORD      = ADDR_WORD_DEF,
    parameter int                TIMEOUT_CYCLES = 50000,
    parameter int                TO_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              addr_hit,
    output logic              frame_err,
    output logic              timeout_err,
    output logic              busy
);

    localparam logic [2:0] LAST_DATA_CNT = 3'(WORD_BYTES - 1);

    rx_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              dv_q, dv_d;
    logic              ah_q, ah_d;
    logic              fe_q, fe_d;
    logic              to_q, to_d;
    logic              expire;

    rx_timeout_timer #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (rx_valid || (state_q == ST_IDLE)),
        .run_i    (state_q != ST_IDLE),
        .expire_o (expire)
    );

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        ah_d    = 1'b0;
        fe_d    = 1'b0;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    sr_d    = {sr_q[WORD_W-BYTE_W-1:0], rx_data};
                    cnt_d   = 3'd1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    sr_d  = {sr_q[WORD_W-BYTE_W-1:0], rx_data};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST_DATA_CNT)
                        state_d = ST_TRAIL;
                end else if (expire) begin
                    to_d    = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_TRAIL: begin
                if (rx_valid) begin
                    if (rx_data == TRAILER) begin
                        data_d = sr_q;
                        dv_d   = 1'b1;
                        ah_d   = (sr_q == ADDR_WORD);
                    end else begin
                        fe_d   = 1'b1;
                    end
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else if (expire) begin
                    to_d    = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            sr_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ah_q    <= 1'b0;
            fe_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ah_q    <= ah_d;
            fe_q    <= fe_d;
            to_q    <= to_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign addr_hit    = ah_q;
    assign frame_err   = fe_q;
    assign timeout_err = to_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_word_assembler_rx.sv
// Directed scoreboard bench for word_assembler_rx with a shortened timeout.
module tb_word_assembler_rx;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] data_out;
    logic        data_valid, addr_hit, frame_err, timeout_err, busy;

    word_assembler_rx #(
        .TRAILER        (8'h01),
        .ADDR_WORD      (32'h0100_0000),
        .TIMEOUT_CYCLES (T),
        .TO_W           (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .addr_hit    (addr_hit),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 word, 1 frame_err, 2 timeout_err
        logic [31:0] word;
        logic        ah;
    } exp_t;

    exp_t exp_q[$];
    int   dv_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever any strobe is presented.
    int   np;
    int   akind;
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            np = int'(data_valid) + int'(frame_err) + int'(timeout_err);
            if (addr_hit && !data_valid) chk("addr_hit_alone", 32'(addr_hit), 32'd0);
            if (np > 1) chk("pulse_overlap", 32'(np), 32'd1);
            if (np != 0) begin
                akind = data_valid ? 0 : (frame_err ? 1 : 2);
                if (data_valid) dv_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse_kind", 32'(akind), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'(akind), 32'(e.kind));
                    if (e.kind == 0) begin
                        chk("data_out", data_out, e.word);
                        chk("addr_hit", 32'(addr_hit), 32'(e.ah));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic put_spaced(input logic [7:0] b);
        put(b);
        repeat (9) tick();
    endtask

    task automatic push_exp(input int kind, input logic [31:0] w, input logic ah);
        exp_t x;
        x.kind = kind;
        x.word = w;
        x.ah   = ah;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {28'd0, data_valid, addr_hit, frame_err, timeout_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: spaced good frame
        push_exp(0, 32'h1234_5678, 1'b0);
        put_spaced(8'h12); put_spaced(8'h34); put_spaced(8'h56); put_spaced(8'h78);
        chk("busy_in_frame", 32'(busy), 32'd1);
        put(8'h01);
        drain("t1_drain");

        // 2: bad trailer leaves data_out untouched
        push_exp(1, 32'h0, 1'b0);
        put_spaced(8'hAA); put_spaced(8'hBB); put_spaced(8'hCC); put_spaced(8'hDD);
        put(8'h02);
        drain("t2_drain");
        chk("t2_hold", data_out, 32'h1234_5678);

        // 3: timeout after partial frame, exact expiry boundary, then address word
        push_exp(2, 32'h0, 1'b0);
        put(8'h11); put(8'h22); put(8'h33);
        repeat (T) tick();
        chk("t3_busy_before_expiry", 32'(busy), 32'd1);
        tick();
        chk("t3_busy_after_expiry", 32'(busy), 32'd0);
        drain("t3_to_drain");
        push_exp(0, 32'h0100_0000, 1'b1);
        put(8'h01); put(8'h00); put(8'h00); put(8'h00); put(8'h01);
        drain("t3_addr_drain");

        // 4: back-to-back frames with no dead cycle
        dv_cyc.delete();
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        push_exp(0, 32'hCAFE_BABE, 1'b0);
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF); put(8'h01);
        put(8'hCA); put(8'hFE); put(8'hBA); put(8'hBE); put(8'h01);
        drain("t4_drain");
        chk("t4_dv_count", 32'(dv_cyc.size()), 32'd2);
        if (dv_cyc.size() == 2) chk("t4_dv_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd5);

        // 5: reset mid-frame discards partial data silently
        put(8'h55); put(8'h66);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_data_out", data_out, 32'h0);
        repeat (3) tick();
        push_exp(0, 32'h0102_0304, 1'b0);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h01);
        drain("t5_drain");

        // 6: byte lands on the expiry cycle and wins
        push_exp(0, 32'hA1B2_C3D4, 1'b0);
        put(8'hA1);
        repeat (T) tick();
        put(8'hB2); put(8'hC3); put(8'hD4);
        repeat (T) tick();
        put(8'h01);
        drain("t6_drain");
        chk("t6_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
